// File: rtl/ysyx_22051086_icache_nway.sv
// ---------------------------------------------------------------------------
// ysyx_22051086_icache_nway
// Read-only, WAYS-way set-associative instruction cache with an AXI4 burst
// refill port and a fence.i style invalidate-all.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_addr      fetch request (PC, bits [1:0] ignored)
//   resp_valid/resp_ready/resp_data   instruction response
//   resp_err                          refill returned a bus error
//   inv_req / inv_done                invalidate-all request / completion pulse
//   ar*                               AXI read address channel (INCR bursts)
//   r*                                AXI read data channel (64-bit beats)
// ---------------------------------------------------------------------------
module ysyx_22051086_icache_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        inv_req,
  output logic        inv_done,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = 32 - OFF - IDX;
  localparam int BEATS = LINE_BYTES / 8;
  localparam int WW    = OFF - 2;                              // word-offset width
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;      // beat index width
  localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;        // way index width

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP, S_INV
  } state_e;

  state_e            state_q;
  logic [TAG-1:0]    tag_r_q;
  logic [IDX-1:0]    idx_q;
  logic [WW-1:0]     word_q;
  logic [PW-1:0]     victim_q;
  logic              evict_q;
  logic [BW-1:0]     beat_q;
  logic              err_q;
  logic              inv_pend_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [PW-1:0]     rr_q    [SETS];
  logic [TAG-1:0]    tag_q   [WAYS][SETS];
  logic [63:0]       data_q  [WAYS][SETS][BEATS];

  logic              hit;
  logic [PW-1:0]     hit_way;
  logic              free_found;
  logic [PW-1:0]     free_way;
  logic [BW-1:0]     req_beat;
  logic [63:0]       hit_beat;
  logic              beat_err;
  logic              refill_beat;
  logic [PW-1:0]     rr_next;

  // Low PC bits select nothing: fetches are always word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_beat    = BW'(word_q >> 1);
  assign hit_beat    = data_q[hit_way][idx_q][req_beat];
  assign beat_err    = err_q | (rresp != 2'b00);
  assign refill_beat = !rst && (state_q == S_REFILL) && rvalid;
  assign rr_next     = (WAYS == 1) ? '0 : PW'(rr_q[idx_q] + 1'b1);

  // Tag compare across all ways, and lowest-index free way for allocation.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loops can leave a value held (which would be a latch).
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx_q] && (tag_q[w][idx_q] == tag_r_q)) begin
        hit     = 1'b1;
        hit_way = PW'(w);
      end
    end
    // Descending scan so the lowest free index is the one that sticks.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx_q]) begin
        free_found = 1'b1;
        free_way   = PW'(w);
      end
    end
  end

  // Controller: state, valid bits, replacement pointers and response regs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      inv_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      inv_pend_q <= inv_pend_q | inv_req;
      case (state_q)
        S_IDLE: begin
          if (inv_pend_q) begin
            state_q <= S_INV;
          end else if (req_valid) begin
            tag_r_q <= req_addr[31 -: TAG];
            idx_q   <= req_addr[OFF +: IDX];
            word_q  <= req_addr[2 +: WW];
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            resp_data_q <= word_q[0] ? hit_beat[63:32] : hit_beat[31:0];
            resp_err_q  <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            victim_q <= free_found ? free_way : rr_q[idx_q];
            evict_q  <= !free_found;
            err_q    <= 1'b0;
            beat_q   <= '0;
            state_q  <= S_MISS;
          end
        end
        S_MISS: begin
          if (arready) state_q <= S_REFILL;
        end
        S_REFILL: begin
          if (rvalid) begin
            beat_q <= (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + 1'b1;
            if (beat_q == req_beat)
              resp_data_q <= word_q[0] ? rdata[63:32] : rdata[31:0];
            if (rresp != 2'b00) err_q <= 1'b1;
            if (rlast) begin
              // The victim's old contents were overwritten either way, so an
              // errored fill leaves the way invalid rather than stale.
              valid_q[victim_q][idx_q] <= !beat_err;
              if (evict_q) rr_q[idx_q] <= rr_next;
              resp_err_q <= beat_err;
              if (beat_err) resp_data_q <= '0;
              beat_q  <= '0;
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (resp_ready) state_q <= (inv_pend_q | inv_req) ? S_INV : S_IDLE;
        end
        S_INV: begin
          for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
          inv_pend_q <= inv_req;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
    // decide whether their contents mean anything.
    if (refill_beat) data_q[victim_q][idx_q][beat_q] <= rdata;
    if (refill_beat && rlast) tag_q[victim_q][idx_q] <= tag_r_q;
  end

  // Outputs decode the registered state and are forced low while rst is high.
  assign req_ready  = !rst && (state_q == S_IDLE) && !inv_pend_q;
  assign resp_valid = !rst && (state_q == S_RESP);
  assign resp_data  = rst ? '0 : resp_data_q;
  assign resp_err   = !rst && resp_err_q;
  assign inv_done   = !rst && (state_q == S_INV);
  assign arvalid    = !rst && (state_q == S_MISS);
  assign araddr     = rst ? '0 : {tag_r_q, idx_q, {OFF{1'b0}}};
  assign arlen      = rst ? 8'd0 : 8'(BEATS - 1);
  assign arsize     = rst ? 3'd0 : 3'd3;
  assign arburst    = rst ? 2'b00 : 2'b01;
  assign rready     = !rst && (state_q == S_REFILL);

endmodule
